// File: rtl/sci2_word_tx_pkg.sv
// SCI2 word transmitter shared definitions: line levels, default
// geometry and frame-width helpers used by the builder and the top.
package sci2_word_tx_pkg;

    // Line levels of the framing bits.
    localparam logic SCI2_START_BIT = 1'b0;
    localparam logic SCI2_STOP_BIT  = 1'b1;

    // Default frame geometry and bit timing.
    localparam int SCI2_DEF_W_DATA     = 8;
    localparam int SCI2_DEF_W_MARK     = 1;
    localparam int SCI2_DEF_N_STOP     = 1;
    localparam int SCI2_DEF_CLK_DIV    = 16;
    localparam int SCI2_DEF_PARITY_ODD = 1;

    // Total line bits per frame: start + data + mark + parity + stop(s).
    function automatic int sci2_frame_width(input int w_data, input int w_mark,
                                            input int n_stop);
        return 2 + w_data + w_mark + n_stop;
    endfunction

    // The mark port keeps at least one bit so it exists when W_MARK is 0.
    function automatic int sci2_mark_port_width(input int w_mark);
        return (w_mark > 0) ? w_mark : 1;
    endfunction

endpackage

// File: rtl/sci2_word_frame.sv
// SCI2 combinational frame builder: computes parity over {mark,data}
// and assembles the complete LSB-first frame ready to be shifted out.
module sci2_word_frame
    import sci2_word_tx_pkg::*;
#(
    parameter  int W_DATA     = SCI2_DEF_W_DATA,
    parameter  int W_MARK     = SCI2_DEF_W_MARK,
    parameter  int N_STOP     = SCI2_DEF_N_STOP,
    parameter  int PARITY_ODD = SCI2_DEF_PARITY_ODD,
    localparam int W_MARK_P   = sci2_mark_port_width(W_MARK),
    localparam int W_FRAME    = sci2_frame_width(W_DATA, W_MARK, N_STOP)
) (
    input  logic [W_DATA-1:0]   i_data,
    input  logic [W_MARK_P-1:0] i_mark,
    output logic [W_FRAME-1:0]  o_frame
);

    localparam int W_PAY = W_DATA + W_MARK;

    logic [W_PAY-1:0] w_payload;
    logic             w_parity;

    // Payload is data followed by the mark bits; without a mark field the
    // single mark port bit carries no information and is left unused.
    generate
        if (W_MARK > 0) begin : g_mark
            assign w_payload = {i_mark[W_MARK-1:0], i_data};
        end else begin : g_no_mark
            logic w_unused_mark;
            assign w_unused_mark = ^i_mark;
            assign w_payload     = i_data;
        end
    endgenerate

    // Odd parity inverts the XOR so the total number of ones comes out odd.
    assign w_parity = (PARITY_ODD != 0) ? ~(^w_payload) : (^w_payload);

    // Bit 0 goes on the line first.
    assign o_frame = {{N_STOP{SCI2_STOP_BIT}}, w_parity, w_payload, SCI2_START_BIT};

endmodule

// File: rtl/sci2_word_tx.sv
// SCI2 word transmitter: accepts a word over valid/ready, frames it and
// serialises it LSB-first at CLK_DIV clocks per line bit.
// Optional macro SCI2_TX_BUF_EN adds a one-word holding buffer so that
// consecutive frames chain with no idle clock between them.
module sci2_word_tx
    import sci2_word_tx_pkg::*;
#(
    parameter  int W_DATA     = SCI2_DEF_W_DATA,
    parameter  int W_MARK     = SCI2_DEF_W_MARK,
    parameter  int N_STOP     = SCI2_DEF_N_STOP,
    parameter  int CLK_DIV    = SCI2_DEF_CLK_DIV,
    parameter  int PARITY_ODD = SCI2_DEF_PARITY_ODD,
    localparam int W_MARK_P   = sci2_mark_port_width(W_MARK)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tx_valid,
    output logic                tx_ready,
    input  logic [W_DATA-1:0]   tx_data,
    input  logic [W_MARK_P-1:0] tx_mark,
    output logic                tx_line,
    output logic                busy,
    output logic                frame_done
);

    localparam int W_FRAME = sci2_frame_width(W_DATA, W_MARK, N_STOP);
    localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W   = $clog2(W_FRAME);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(W_FRAME - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]         r_state;
    logic [W_FRAME-1:0] r_shreg;
    logic [BIT_W-1:0]   r_bit_cnt;
    logic [DIV_W-1:0]   r_div_cnt;
    logic               r_ready_en;

    logic [W_FRAME-1:0] w_frame;
    logic [W_FRAME-1:0] w_load_frame;
    logic               w_accept;
    logic               w_last;
    logic               w_buf_load;
    logic               w_start;

    sci2_word_frame #(
        .W_DATA     (W_DATA),
        .W_MARK     (W_MARK),
        .N_STOP     (N_STOP),
        .PARITY_ODD (PARITY_ODD)
    ) u_frame (
        .i_data  (tx_data),
        .i_mark  (tx_mark),
        .o_frame (w_frame)
    );

    assign w_accept = tx_valid & tx_ready;
    assign w_last   = (r_state == ST_SHIFT) && (r_bit_cnt == BIT_LAST)
                      && (r_div_cnt == DIV_LAST);

`ifdef SCI2_TX_BUF_EN
    logic               r_buf_full;
    logic [W_FRAME-1:0] r_buf_frame;

    // A word may be taken whenever the holding buffer is empty.
    assign tx_ready     = ~rst & r_ready_en & ~r_buf_full;
    assign w_buf_load   = w_last & r_buf_full;
    assign w_load_frame = w_buf_load ? r_buf_frame : w_frame;

    // Buffer occupancy: filled by a mid-frame accept, drained at frame end.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf_full <= 1'b0;
        end else if (w_accept && (r_state == ST_SHIFT) && !w_last) begin
            r_buf_full <= 1'b1;
        end else if (w_buf_load) begin
            r_buf_full <= 1'b0;
        end
    end

    // Buffered frame contents, captured with the mid-frame accept.
    // NOTE: pure datapath storage gets no reset; r_buf_full guards its use.
    always_ff @(posedge clk) begin
        if (w_accept && (r_state == ST_SHIFT) && !w_last) begin
            r_buf_frame <= w_frame;
        end
    end
`else
    // Without a buffer a word is only taken while the line is idle.
    assign tx_ready     = ~rst & r_ready_en & (r_state == ST_IDLE);
    assign w_buf_load   = 1'b0;
    assign w_load_frame = w_frame;
`endif

    // A frame starts from idle, or chains directly on the last stop clock.
    assign w_start = (w_accept & ((r_state == ST_IDLE) | w_last)) | w_buf_load;

    // Frame sequencer: load, hold each bit CLK_DIV clocks, shift, finish.
    // NOTE: state uses <= so every register here sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_shreg    <= '1;
            r_bit_cnt  <= '0;
            r_div_cnt  <= '0;
            r_ready_en <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            if (w_start) begin
                r_state   <= ST_SHIFT;
                r_shreg   <= w_load_frame;
                r_bit_cnt <= '0;
                r_div_cnt <= '0;
            end else if (w_last) begin
                r_state   <= ST_IDLE;
                r_bit_cnt <= '0;
                r_div_cnt <= '0;
            end else if (r_state == ST_SHIFT) begin
                if (r_div_cnt == DIV_LAST) begin
                    r_div_cnt <= '0;
                    r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                    r_shreg   <= {SCI2_STOP_BIT, r_shreg[W_FRAME-1:1]};
                end else begin
                    r_div_cnt <= r_div_cnt + DIV_W'(1);
                end
            end
        end
    end

    assign busy       = (r_state == ST_SHIFT);
    assign tx_line    = (r_state == ST_SHIFT) ? r_shreg[0] : SCI2_STOP_BIT;
    assign frame_done = w_last & ~rst;

endmodule

// File: tb/tb_sci2_word_tx.sv
// Directed bench for sci2_word_tx: three instances with CLK_DIV=4
// (odd parity, even parity, two stop bits without mark) driven from
// hand-computed frame vectors.
module tb_sci2_word_tx;

`ifdef SCI2_TX_BUF_EN
    localparam int GAP   = 0;
    localparam int ACC_C = 1;
`else
    localparam int GAP   = 1;
    localparam int ACC_C = 49;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] data;
    logic       mark;
    logic       va, ve, vs;
    logic       rdy_a, line_a, busy_a, done_a;
    logic       rdy_e, line_e, busy_e, done_e;
    logic       rdy_s, line_s, busy_s, done_s;

    int n_pass  = 0;
    int n_total = 0;

    sci2_word_tx #(.W_DATA(8), .W_MARK(1), .N_STOP(1), .CLK_DIV(4), .PARITY_ODD(1)) dut_a (
        .clk(clk), .rst(rst), .tx_valid(va), .tx_ready(rdy_a), .tx_data(data),
        .tx_mark(mark), .tx_line(line_a), .busy(busy_a), .frame_done(done_a));

    sci2_word_tx #(.W_DATA(8), .W_MARK(1), .N_STOP(1), .CLK_DIV(4), .PARITY_ODD(0)) dut_e (
        .clk(clk), .rst(rst), .tx_valid(ve), .tx_ready(rdy_e), .tx_data(data),
        .tx_mark(mark), .tx_line(line_e), .busy(busy_e), .frame_done(done_e));

    sci2_word_tx #(.W_DATA(8), .W_MARK(0), .N_STOP(2), .CLK_DIV(4), .PARITY_ODD(1)) dut_s (
        .clk(clk), .rst(rst), .tx_valid(vs), .tx_ready(rdy_s), .tx_data(data),
        .tx_mark(mark), .tx_line(line_s), .busy(busy_s), .frame_done(done_s));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    endtask

    // Sends one word to all three instances and checks every clock of the
    // frame; called at posedge+1 of an idle cycle, returns likewise.
    task automatic run_frame(input string tag, input logic [7:0] d, input logic m,
                             input logic [11:0] ea, input logic [11:0] ee,
                             input logic [11:0] es);
        logic exp_done;
        data = d; mark = m; va = 1'b1; ve = 1'b1; vs = 1'b1;
        @(negedge clk);
        check({tag, " ready_a"}, rdy_a, 1'b1);
        check({tag, " ready_e"}, rdy_e, 1'b1);
        check({tag, " ready_s"}, rdy_s, 1'b1);
        @(posedge clk); #1;
        va = 1'b0; ve = 1'b0; vs = 1'b0; data = ~d; mark = ~m;
        for (int c = 1; c <= 48; c++) begin
            @(negedge clk);
            exp_done = (c == 48);
            check($sformatf("%s c%0d line_a", tag, c), line_a, ea[(c-1)/4]);
            check($sformatf("%s c%0d line_e", tag, c), line_e, ee[(c-1)/4]);
            check($sformatf("%s c%0d line_s", tag, c), line_s, es[(c-1)/4]);
            check($sformatf("%s c%0d done_a", tag, c), done_a, exp_done);
            check($sformatf("%s c%0d done_e", tag, c), done_e, exp_done);
            check($sformatf("%s c%0d done_s", tag, c), done_s, exp_done);
            check($sformatf("%s c%0d busy_s", tag, c), busy_s, 1'b1);
        end
        @(negedge clk);
        check({tag, " after busy_a"}, busy_a, 1'b0);
        check({tag, " after busy_s"}, busy_s, 1'b0);
        check({tag, " after line_a"}, line_a, 1'b1);
        check({tag, " after line_s"}, line_s, 1'b1);
        check({tag, " after done_a"}, done_a, 1'b0);
        check({tag, " after ready_a"}, rdy_a, 1'b1);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [11:0] ea, e2;
        logic        exp_line, exp_busy, exp_done, exp_rdy;
        rst = 1'b1; va = 1'b0; ve = 1'b0; vs = 1'b0; data = 8'h00; mark = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst line_a", line_a, 1'b1);
        check("rst ready_a", rdy_a, 1'b0);
        check("rst busy_a", busy_a, 1'b0);
        check("rst done_a", done_a, 1'b0);
        check("rst line_s", line_s, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("post-rst ready_a", rdy_a, 1'b1);
        check("post-rst line_a", line_a, 1'b1);
        @(posedge clk); #1;

        // 0xA5 mark 1: odd 0,1,0,1,0,0,1,0,1,1,0,1; even parity 1; no-mark frame parity 1.
        run_frame("a5", 8'hA5, 1'b1, 12'hB4A, 12'hF4A, 12'hF4A);
        // All zeros: odd parity 1, even parity 0.
        run_frame("zero", 8'h00, 1'b0, 12'hC00, 12'h800, 12'hE00);
        // All ones: twelve-bit two-stop frame ends 1,1.
        run_frame("ones", 8'hFF, 1'b1, 12'hBFE, 12'hFFE, 12'hFFE);

        // Back-to-back with tx_valid held and data churning while held off.
        ea = 12'hB4A;
        e2 = 12'hC00;
        data = 8'hA5; mark = 1'b1; va = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= 48 + GAP + 48 + 2; c++) begin
            va   = (c <= ACC_C);
            data = (c == ACC_C) ? 8'h00 : 8'(c * 29 + 3);
            mark = (c == ACC_C) ? 1'b0 : c[0];
            @(negedge clk);
            if (c <= 48) begin
                exp_line = ea[(c-1)/4]; exp_busy = 1'b1;
            end else if (c <= 48 + GAP) begin
                exp_line = 1'b1; exp_busy = 1'b0;
            end else if (c <= 96 + GAP) begin
                exp_line = e2[(c-49-GAP)/4]; exp_busy = 1'b1;
            end else begin
                exp_line = 1'b1; exp_busy = 1'b0;
            end
            exp_done = (c == 48) || (c == 96 + GAP);
`ifdef SCI2_TX_BUF_EN
            exp_rdy = (c == 1) || (c > 48);
`else
            exp_rdy = (c == 49) || (c > 97);
`endif
            check($sformatf("b2b c%0d line", c), line_a, exp_line);
            check($sformatf("b2b c%0d busy", c), busy_a, exp_busy);
            check($sformatf("b2b c%0d done", c), done_a, exp_done);
            check($sformatf("b2b c%0d ready", c), rdy_a, exp_rdy);
            @(posedge clk); #1;
        end
        va = 1'b0;

        // Reset during bit 5 of a frame.
        ea = 12'hBFE;
        data = 8'hFF; mark = 1'b1; va = 1'b1;
        @(posedge clk); #1;
        va = 1'b0;
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            check($sformatf("rstmid c%0d line", c), line_a, ea[(c-1)/4]);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        check("rstmid in-rst done", done_a, 1'b0);
        check("rstmid in-rst ready", rdy_a, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstmid next line", line_a, 1'b1);
        check("rstmid next busy", busy_a, 1'b0);
        check("rstmid next done", done_a, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rstmid ready back", rdy_a, 1'b1);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            check($sformatf("rstmid quiet%0d done", c), done_a, 1'b0);
            check($sformatf("rstmid quiet%0d line", c), line_a, 1'b1);
        end
        @(posedge clk); #1;
        run_frame("after-rst", 8'hA5, 1'b1, 12'hB4A, 12'hF4A, 12'hF4A);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
